// File: rtl/mdio_receiver.sv
// -----------------------------------------------------------------------------
// mdio_receiver
// PHY-side clause-22 MDIO management slave. It sits directly downstream of the
// MDIO frame generator, decodes 32-bit frames (no preamble) and drives a
// simple register-file port. On reads it returns the register word serially
// on mdio_in, one bit per MDC falling edge.
//
// MDC is a clk/2 signal from the same clock domain, so no synchronizer is
// used. Edges of MDC are detected against a registered copy.
//
// Optional feature (compile-time macro MDIO_ADDR_FILTER_EN):
//   defined   - PHYAD must equal PHY_ADDR, otherwise the frame is ignored
//   undefined - PHYAD is ignored, every well-formed frame is answered
//
// Ports:
//   clk       system clock
//   reset     asynchronous reset, active low
//   mdc       management clock from the generator
//   mdio_oe   generator drive enable (1 = mdio_out valid)
//   mdio_out  serial data from the generator
//   rd_data   register-file read data, combinational on addr
//   mdio_in   serial read data back to the generator
//   addr      register address (REGAD of the last frame)
//   wr_data   write data of the last completed write
//   wr_stb    one-clk write strobe
//   rd_stb    one-clk strobe when rd_data is captured
// -----------------------------------------------------------------------------
module mdio_receiver #(
    parameter logic [4:0]  PHY_ADDR = 5'h15,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mdc,
    input  logic              mdio_oe,
    input  logic              mdio_out,
    input  logic [DATA_W-1:0] rd_data,
    output logic              mdio_in,
    output logic [4:0]        addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_stb,
    output logic              rd_stb
);

`ifdef MDIO_ADDR_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WR,
        S_RD,
        S_WAIT_IDLE
    } state_t;

    // Frame bit numbers (1-based, as counted by cnt after the shift).
    localparam logic [5:0] BIT_REGAD = 6'd14;
    localparam logic [5:0] BIT_TA    = 6'd16;
    localparam logic [5:0] BIT_LAST  = 6'd32;

    state_t            state_q, state_d;
    logic              mdc_q;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [4:0]        addr_q, addr_d;
    logic              mdio_in_q, mdio_in_d;
    logic              wr_stb_q, wr_stb_d;
    logic              rd_stb_q, rd_stb_d;

    logic              rise, fall;
    logic [5:0]        cnt_inc, cnt_sat;
    logic [DATA_W-1:0] rx_shift;
    logic [1:0]        hdr_st, hdr_op;
    logic [4:0]        hdr_phyad;
    logic              hdr_bad;

    assign rise     = mdc & ~mdc_q;
    assign fall     = ~mdc & mdc_q;
    assign cnt_inc  = cnt_q + 6'd1;
    // While waiting out an unwanted frame the counter runs but parks at 32.
    assign cnt_sat  = (cnt_q >= BIT_LAST) ? BIT_LAST : cnt_inc;
    assign rx_shift = {rx_q[DATA_W-2:0], mdio_out};

    // Header fields as they stand once bit 16 is being shifted in.
    assign hdr_st    = rx_shift[15:14];
    assign hdr_op    = rx_shift[13:12];
    assign hdr_phyad = rx_shift[11:7];
    assign hdr_bad   = (hdr_st != 2'b01) || (hdr_op == 2'b00) || (hdr_op == 2'b11)
                     || (FILTER_ON && (hdr_phyad != PHY_ADDR));

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mdc_q     <= 1'b0;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            wr_data_q <= '0;
            addr_q    <= '0;
            mdio_in_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mdc_q     <= mdc;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            wr_data_q <= wr_data_d;
            addr_q    <= addr_d;
            mdio_in_q <= mdio_in_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (rise && mdio_oe) state_d = S_HDR;
            end
            S_HDR: begin
                if (rise && (cnt_inc == BIT_TA)) begin
                    if (hdr_bad)                state_d = S_WAIT_IDLE;
                    else if (hdr_op == 2'b01)   state_d = S_WR;
                    else                        state_d = S_RD;
                end
            end
            S_WR: begin
                if (rise && (!mdio_oe || (cnt_inc == BIT_LAST))) state_d = S_IDLE;
            end
            S_RD: begin
                if (rise && (cnt_inc == BIT_LAST)) state_d = S_IDLE;
            end
            S_WAIT_IDLE: begin
                if (rise && !mdio_oe && (cnt_sat == BIT_LAST)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next-values.
    always_comb begin
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        wr_data_d = wr_data_q;
        addr_d    = addr_q;
        mdio_in_d = mdio_in_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise && mdio_oe) begin
                    rx_d  = {{(DATA_W-1){1'b0}}, mdio_out};
                    cnt_d = 6'd1;
                end
            end
            S_HDR: begin
                if (rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_inc;
                    if (cnt_inc == BIT_REGAD) addr_d = rx_shift[4:0];
                    // addr was latched two MDC periods ago, so rd_data is settled.
                    if ((cnt_inc == BIT_TA) && !hdr_bad && (hdr_op == 2'b10)) begin
                        tx_d     = rd_data;
                        rd_stb_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (rise && mdio_oe) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_inc;
                    if (cnt_inc == BIT_LAST) begin
                        wr_data_d = rx_shift;
                        wr_stb_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                // Falls after rises 16..31 present frame bits 17..32.
                if (fall) begin
                    mdio_in_d = tx_q[DATA_W-1];
                    tx_d      = {tx_q[DATA_W-2:0], 1'b0};
                end
                if (rise) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BIT_LAST) mdio_in_d = 1'b0;
                end
            end
            S_WAIT_IDLE: begin
                if (rise) cnt_d = cnt_sat;
            end
            default: ;
        endcase
    end

    assign mdio_in = mdio_in_q;
    assign addr    = addr_q;
    assign wr_data = wr_data_q;
    assign wr_stb  = wr_stb_q;
    assign rd_stb  = rd_stb_q;

endmodule

// File: tb/tb_mdio_receiver.sv
// -----------------------------------------------------------------------------
// tb_mdio_receiver
// Self-checking bench for mdio_receiver. Acts as the MDIO frame generator
// (MDC = clk/2) and as a read-only register file. Expected results come from
// a frame-level model: a frame is answered when ST=01, OP is 01/10 and (with
// the address filter) PHYAD matches; writes complete unless mdio_oe drops.
// -----------------------------------------------------------------------------
module tb_mdio_receiver;

    localparam logic [4:0] PHY = 5'h15;
`ifdef MDIO_ADDR_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mdc;
    logic        mdio_oe;
    logic        mdio_out;
    logic [15:0] rd_data;
    logic        mdio_in;
    logic [4:0]  addr;
    logic [15:0] wr_data;
    logic        wr_stb;
    logic        rd_stb;

    logic [15:0] rom [0:31];
    assign rd_data = rom[addr];

    mdio_receiver #(.PHY_ADDR(PHY), .DATA_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .mdc      (mdc),
        .mdio_oe  (mdio_oe),
        .mdio_out (mdio_out),
        .rd_data  (rd_data),
        .mdio_in  (mdio_in),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_stb   (wr_stb),
        .rd_stb   (rd_stb)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    logic [15:0] stb_data [$];
    logic [15:0] exp_wr_data;

    // Strobe monitor: counts high samples so a stretched pulse is caught.
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            wr_pulses++;
            stb_data.push_back(wr_data);
        end
        if (rd_stb === 1'b1) rd_pulses++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One MDC period: low phase (data changes), then high phase (slave samples).
    // mdio_in is returned as seen just before the rising edge.
    task automatic drive_bit(input logic b, input logic oe, output logic seen);
        @(negedge clk);
        mdc      = 1'b0;
        mdio_out = b;
        mdio_oe  = oe;
        @(negedge clk);
        seen = mdio_in;
        mdc  = 1'b1;
    endtask

    function automatic bit frame_ok(input logic [31:0] f);
        logic [1:0] st;
        logic [1:0] op;
        st = f[31:30];
        op = f[29:28];
        return (st == 2'b01) && (op == 2'b01 || op == 2'b10) && (!FILTER || f[27:23] == PHY);
    endfunction

    // Drives one frame; read frames release mdio_oe from the turnaround on.
    // drop_bit != 0 releases mdio_oe from that bit to the end of the frame.
    task automatic drive_frame(input logic [31:0] f, input int drop_bit, output logic [15:0] rword);
        logic s;
        logic oe;
        bit   is_rd;
        is_rd = (f[29:28] == 2'b10);
        rword = '0;
        for (int k = 1; k <= 32; k++) begin
            oe = !((is_rd && k >= 15) || (drop_bit != 0 && k >= drop_bit));
            drive_bit(f[32-k], oe, s);
            if (k >= 17) rword = {rword[14:0], s};
        end
    endtask

    task automatic idle_bits(input int n);
        logic s;
        for (int g = 0; g < n; g++) drive_bit(1'($urandom), 1'b0, s);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_and_check(input logic [31:0] f, input int drop_bit, input int gap, input string tag);
        int          wr0;
        int          rd0;
        logic [15:0] rword;
        bit          exp_wr;
        bit          exp_rd;
        wr0 = wr_pulses;
        rd0 = rd_pulses;
        drive_frame(f, drop_bit, rword);
        idle_bits(gap);
        exp_wr = frame_ok(f) && f[29:28] == 2'b01 && drop_bit == 0;
        exp_rd = frame_ok(f) && f[29:28] == 2'b10;
        if (exp_wr) exp_wr_data = f[15:0];
        check({tag, ".wr_stb"},  32'(wr_pulses - wr0), {31'd0, exp_wr});
        check({tag, ".rd_stb"},  32'(rd_pulses - rd0), {31'd0, exp_rd});
        check({tag, ".addr"},    {27'd0, addr},        {27'd0, f[22:18]});
        check({tag, ".wr_data"}, {16'd0, wr_data},     {16'd0, exp_wr_data});
        check({tag, ".rdword"},  {16'd0, rword},       exp_rd ? {16'd0, rom[f[22:18]]} : 32'd0);
        check({tag, ".mdio_in"}, {31'd0, mdio_in},     32'd0);
    endtask

    initial begin
        logic [31:0] fa;
        logic [31:0] fb;
        logic [15:0] rw;
        logic        s;
        int          wr0;
        logic [1:0]  st;
        logic [4:0]  ph;

        reset    = 1'b0;
        mdc      = 1'b0;
        mdio_oe  = 1'b0;
        mdio_out = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        check("rst.mdio_in", {31'd0, mdio_in}, 32'd0);
        check("rst.addr",    {27'd0, addr},    32'd0);
        check("rst.wr_data", {16'd0, wr_data}, 32'd0);
        check("rst.wr_stb",  {31'd0, wr_stb},  32'd0);
        check("rst.rd_stb",  {31'd0, rd_stb},  32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp_wr_data = '0;

        run_and_check(32'h5AB8_7652, 0, 1, "wr_basic");
        rom[5'h0E] = 16'hC3A5;
        run_and_check(32'h6AB8_AAAA, 0, 1, "rd_basic");
        run_and_check({2'b01, 2'b01, 5'h03, 5'h0E, 2'b10, 16'hBEEF}, 0, 1, "wr_phy03");
        run_and_check({2'b01, 2'b01, PHY, 5'h07, 2'b10, 16'h1234}, 24, 1, "wr_abort");
        run_and_check({2'b01, 2'b01, PHY, 5'h09, 2'b10, 16'h4321}, 0, 1, "wr_after_abort");
        run_and_check({2'b11, 2'b01, PHY, 5'h0A, 2'b10, 16'h5555}, 0, 1, "st11");
        run_and_check({2'b01, 2'b01, PHY, 5'h0B, 2'b10, 16'hA5A5}, 0, 1, "wr_after_st11");

        // Back-to-back writes: second frame starts on the rise after bit 32.
        fa  = {2'b01, 2'b01, PHY, 5'h11, 2'b10, 16'h0F0F};
        fb  = {2'b01, 2'b01, PHY, 5'h12, 2'b10, 16'hF00D};
        wr0 = wr_pulses;
        stb_data.delete();
        drive_frame(fa, 0, rw);
        drive_frame(fb, 0, rw);
        idle_bits(1);
        exp_wr_data = 16'hF00D;
        check("b2b.wr_stb",  32'(wr_pulses - wr0), 32'd2);
        check("b2b.first",   {16'd0, (stb_data.size() > 0) ? stb_data[0] : 16'hxxxx}, 32'h0F0F);
        check("b2b.wr_data", {16'd0, wr_data}, 32'hF00D);
        check("b2b.addr",    {27'd0, addr},    32'h12);

        // Asynchronous reset in the middle of a read (bit 20).
        rom[5'h0E] = 16'hFFFF;
        fa = 32'h6AB8_AAAA;
        for (int k = 1; k <= 20; k++) drive_bit(fa[32-k], k < 15, s);
        check("mid_rd.mdio_in_pre", {31'd0, s}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rd.mdio_in", {31'd0, mdio_in}, 32'd0);
        check("mid_rd.addr",    {27'd0, addr},    32'd0);
        check("mid_rd.wr_data", {16'd0, wr_data}, 32'd0);
        check("mid_rd.wr_stb",  {31'd0, wr_stb},  32'd0);
        check("mid_rd.rd_stb",  {31'd0, rd_stb},  32'd0);
        mdc     = 1'b0;
        mdio_oe = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_wr_data = '0;
        repeat (2) @(negedge clk);
        rom[5'h0E] = 16'hC3A5;
        run_and_check(32'h6AB8_AAAA, 0, 1, "rd_after_rst");

        // Randomized frames, mostly well-formed.
        for (int n = 0; n < 24; n++) begin
            st = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b01;
            ph = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PHY;
            fa = {st, 2'($urandom), ph, 5'($urandom), 2'b10, 16'($urandom)};
            run_and_check(fa, 0, $urandom_range(1, 3), $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_receiver.md
Name: mdio_receiver

Overview:
- PHY-side MDIO management slave, directly downstream of the MDIO frame generator.
- Consumes the generator's MDC, MDIO_OUT and MDIO_OE; decodes 32-bit clause-22 frames (no preamble); drives a register-file port.
- On reads, returns register data serially on mdio_in, which feeds the generator.

Parameters:
- PHY_ADDR, 5'h15, PHY address this slave answers to (used only with MDIO_ADDR_FILTER_EN).
- DATA_W, 16, register data width; frame layout fixed for 16.

Ports:
- clk  input  1  system clock; MDC is a clk/2 signal from the generator in the same domain, so no synchronizer.
- reset  input  1  asynchronous, active-low reset.
- mdc  input  1  management clock from generator.
- mdio_oe  input  1  generator drive enable; 1 = mdio_out valid.
- mdio_out  input  1  serial data from generator.
- rd_data  input  16  register-file read data, combinational on addr.
- mdio_in  output  1  serial read data to generator.
- addr  output  5  register address (REGAD).
- wr_data  output  16  write data.
- wr_stb  output  1  one-clk write pulse.
- rd_stb  output  1  one-clk pulse when rd_data is captured.

Behaviour:
- Edge detect: mdc_q is mdc registered. rise = mdc & ~mdc_q; fall = ~mdc & mdc_q. All actions occur on the clk edge where rise or fall is true.
- Reset (reset=0, any state, any time): state IDLE, bit counter 0, shift registers 0, mdio_in=0, addr=0, wr_data=0, wr_stb=0, rd_stb=0.
- Frame layout, MSB first: ST[1:0]=01, OP[1:0] (01 write, 10 read), PHYAD[4:0], REGAD[4:0], TA[1:0], DATA[15:0].
- IDLE: on rise with mdio_oe=1, shift mdio_out in as bit 1, set count=1, go to HDR. Rises with mdio_oe=0 are ignored.
- HDR: shift one bit per rise.
  - After bit 14: latch addr=REGAD.
  - TA bits 15–16 are shifted but their value is ignored; mdio_oe is don't-care during TA.
  - On bit 16: if ST≠01, OP∈{00,11}, or the address filter misses, go to WAIT_IDLE.
  - Otherwise, OP=01 goes to WR.
  - Otherwise, OP=10 captures rd_data into tx shift register, pulses rd_stb, and goes to RD.
- WR: shift one bit per rise with mdio_oe=1.
  - If mdio_oe=0 at any rise, abort to IDLE with no wr_stb.
  - On bit 32: wr_data ← shifted word; wr_stb=1 for exactly one clk; go to IDLE.
- RD:
  - On each fall, drive mdio_in=tx[15] and shift tx left. Bit 17 of the frame is presented after the first fall following the bit-16 rise.
  - After 16 falls have been driven, count the next rise (bit 32 sampled by generator), set mdio_in=0, go to IDLE.
- WAIT_IDLE: ignore traffic; return to IDLE on the first rise where mdio_oe=0 and the count has reached 32 (count keeps running). Outputs are unchanged.
- Back-to-back frames: a new frame may start on the rise after the 32nd bit. IDLE accepts it in the same cycle wr_stb pulses.
- addr/wr_data hold their last values between frames. mdio_in is 0 whenever not in RD.

Optional Feature:
- MDIO_ADDR_FILTER_EN
  - Defined: PHYAD must equal PHY_ADDR; on mismatch the frame goes to WAIT_IDLE, with no wr_stb/rd_stb and mdio_in=0.
  - Undefined: PHYAD is ignored; every well-formed frame is answered.

Test Plan:
- Write 32'h5AB87652 (PHYAD 0x15, REGAD 0x0E), filter on -> wr_stb single pulse after bit 32; addr=0x0E; wr_data=16'h7652.
- Read 32'h6AB8AAAA with rd_data=16'hC3A5 -> rd_stb pulse after bit 16; mdio_in shows 1100_0011_1010_0101 on bits 17–32; mdio_in=0 afterwards.
- Write with PHYAD=0x03, MDIO_ADDR_FILTER_EN defined -> no wr_stb, wr_data unchanged. Same frame, macro undefined -> wr_stb, wr_data=low 16 bits.
- Write with mdio_oe dropped at bit 24 -> abort to IDLE, no wr_stb; a following valid write completes normally.
- Assert reset low mid-read at bit 20 -> mdio_in=0 and all outputs 0 immediately (asynchronous); after release, the next read frame is answered correctly.
- Frame with ST=11 -> WAIT_IDLE, no strobes; a following valid write is accepted.
